// File: rtl/fp_half_pkg.sv
// ---------------------------------------------------------------------------
// fp_half_pkg
//   Shared constants and types for the sequential half-precision divider.
//   - Field widths, bias and quotient length (QB = MAN_W + 3 quotient bits).
//   - The divider FSM state encoding.
//   - Result bundle used to register all outputs together.
// ---------------------------------------------------------------------------
package fp_half_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;
    localparam int QB    = MAN_W + 3;
    // Signed working width for the result exponent (room for sign and carry).
    localparam int E_W   = EXP_W + 2;
    localparam int CNT_W = $clog2(QB + 1);

    localparam logic [EXP_W-1:0]        EXP_ALL_ONES = '1;
    localparam logic [MAN_W-1:0]        QNAN_MAN     = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [E_W-1:0]   BIAS_E       = E_W'(BIAS);
    localparam logic signed [E_W-1:0]   E_MAX        = E_W'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } fdiv_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             ovf;
        logic             unf;
        logic             dbz;
    } fdiv_result_t;

endpackage

// File: rtl/fdiv_mant_core.sv
// ---------------------------------------------------------------------------
// fdiv_mant_core
//   Restoring mantissa divider, one quotient bit per step, MSB first.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     load         capture r = {1,m1}, d = {1,m2}; clear q and the bit counter
//     step         perform one restoring iteration
//     m1, m2       stored fractions of dividend / divisor
//     q            QB-bit quotient, q[QB-1] is the first bit produced
//     r_nonzero    partial remainder is non-zero (feeds sticky)
//     last_step    the current step produces the final quotient bit
// ---------------------------------------------------------------------------
module fdiv_mant_core
    import fp_half_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [MAN_W-1:0] m1,
    input  logic [MAN_W-1:0] m2,
    output logic [QB-1:0]    q,
    output logic             r_nonzero,
    output logic             last_step
);

    // r carries one bit of headroom: it stays below 2*d, and d < 2^(MAN_W+1).
    logic [MAN_W+1:0] r_q;
    logic [MAN_W+1:0] r_next;
    logic [MAN_W:0]   d_q;
    logic [QB-1:0]    q_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_bit;

    // NOTE: every variable driven here is assigned on every path; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        q_bit  = (r_q >= {1'b0, d_q});
        r_next = q_bit ? (r_q - {1'b0, d_q}) : r_q;
        r_next = r_next << 1;
    end

    // NOTE: the datapath registers are reset as well, so q and r_nonzero are
    // defined straight out of reset instead of carrying X into the top level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            d_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would let later lines see updates.
            r_q   <= {1'b0, 1'b1, m1};
            d_q   <= {1'b1, m2};
            q_q   <= '0;
            cnt_q <= '0;
        end else if (step) begin
            q_q   <= {q_q[QB-2:0], q_bit};
            r_q   <= r_next;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign q         = q_q;
    assign r_nonzero = (r_q != '0);
    assign last_step = (cnt_q == CNT_W'(QB - 1));

endmodule

// File: rtl/fdiv_half_precision_seq.sv
// ---------------------------------------------------------------------------
// fdiv_half_precision_seq
//   Sequential IEEE-754 half-precision divider (op1 / op2) on split fields.
//   Timeline after an accepted start: QB DIVIDE cycles, one NORM cycle that
//   writes the result registers, then one DONE cycle with done=1 (done in the
//   15th cycle). Zero operands skip straight to DONE in the next cycle.
//   Start is accepted in IDLE or DONE and ignored while busy.
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     start                            divide request
//     in_Sign_1/2, in_Exponent_1/2,
//     in_Mantissa_1/2                  dividend (1) and divisor (2) fields
//     busy                             high in DIVIDE and NORM
//     done                             one-cycle result-valid pulse
//     out_Sign, out_Exponent,
//     out_Mantissa                     registered result
//     Exponent_Overflow/Underflow      result exponent out of range
//     Div_By_Zero                      divisor exponent is zero
//   Configuration macro: FDIV_ROUND_EN (round-to-nearest-even; default
//   build truncates).
// ---------------------------------------------------------------------------
module fdiv_half_precision_seq
    import fp_half_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_Sign_1,
    input  logic             in_Sign_2,
    input  logic [EXP_W-1:0] in_Exponent_1,
    input  logic [EXP_W-1:0] in_Exponent_2,
    input  logic [MAN_W-1:0] in_Mantissa_1,
    input  logic [MAN_W-1:0] in_Mantissa_2,
    output logic             busy,
    output logic             done,
    output logic             out_Sign,
    output logic [EXP_W-1:0] out_Exponent,
    output logic [MAN_W-1:0] out_Mantissa,
    output logic             Exponent_Overflow,
    output logic             Exponent_Underflow,
    output logic             Div_By_Zero
);

    fdiv_state_t             state_q, state_d;
    logic                    accept, special_in;
    logic                    core_load, core_step, core_last, core_r_nonzero;
    logic [QB-1:0]           core_q;
    logic                    res_we;
    logic                    sign_q;
    logic [EXP_W-1:0]        exp1_q, exp2_q;
    fdiv_result_t            res_q, res_d, special_res, norm_res;

    logic signed [E_W-1:0]   e_diff, e_norm, e_fin;
    logic [MAN_W-1:0]        man_norm, man_fin;
    logic                    guard, sticky;

    // Exponent zero means the operand is zero; no denormals.
    assign special_in = (in_Exponent_1 == '0) || (in_Exponent_2 == '0);
    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        res_we    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (accept) begin
                    if (special_in) begin
                        res_we  = 1'b1;
                        state_d = DONE;
                    end else begin
                        core_load = 1'b1;
                        state_d   = DIVIDE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                busy      = 1'b1;
                core_step = 1'b1;
                if (core_last) state_d = NORM;
            end
            NORM: begin
                busy    = 1'b1;
                res_we  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only sign and exponents are needed after the start edge; the mantissas
    // are captured by the core on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp1_q <= '0;
            exp2_q <= '0;
        end else if (accept) begin
            sign_q <= in_Sign_1 ^ in_Sign_2;
            exp1_q <= in_Exponent_1;
            exp2_q <= in_Exponent_2;
        end
    end

    fdiv_mant_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (core_load),
        .step      (core_step),
        .m1        (in_Mantissa_1),
        .m2        (in_Mantissa_2),
        .q         (core_q),
        .r_nonzero (core_r_nonzero),
        .last_step (core_last)
    );

    // ---------------- Normalise ----------------
    assign e_diff = $signed({2'b00, exp1_q}) - $signed({2'b00, exp2_q}) + BIAS_E;

    // Quotient of two [1,2) mantissas lies in (0.5, 2): either q[QB-1] is the
    // leading one, or q[QB-2] is and the exponent drops by one.
    always_comb begin
        if (core_q[QB-1]) begin
            man_norm = core_q[QB-2:2];
            guard    = core_q[1];
            sticky   = core_q[0] | core_r_nonzero;
            e_norm   = e_diff;
        end else begin
            man_norm = core_q[QB-3:1];
            guard    = core_q[0];
            sticky   = core_r_nonzero;
            e_norm   = e_diff - E_W'(1);
        end
    end

    // ---------------- Round ----------------
`ifdef FDIV_ROUND_EN
    logic [MAN_W:0] man_inc;

    always_comb begin
        man_inc = {1'b0, man_norm} + (MAN_W+1)'(1);
        man_fin = man_norm;
        e_fin   = e_norm;
        if (guard && (sticky || man_norm[0])) begin
            // A carry out of the fraction means 1.111..1 rounded to 10.0:
            // fraction wraps to zero and the exponent bumps.
            man_fin = man_inc[MAN_W-1:0];
            if (man_inc[MAN_W]) e_fin = e_norm + E_W'(1);
        end
    end
`else
    logic unused_round_bits;

    assign man_fin = man_norm;
    assign e_fin   = e_norm;
    // Truncation drops the rounding bits; keep them tied off explicitly.
    assign unused_round_bits = guard ^ sticky;
`endif

    // ---------------- Range check and result select ----------------
    always_comb begin
        norm_res      = '0;
        norm_res.sign = sign_q;
        if (e_fin >= E_MAX) begin
            norm_res.ovf = 1'b1;
            norm_res.exp = EXP_ALL_ONES;
        end else if (e_fin[E_W-1] || (e_fin == '0)) begin
            norm_res.unf = 1'b1;
        end else begin
            norm_res.exp = e_fin[EXP_W-1:0];
            norm_res.man = man_fin;
        end
    end

    always_comb begin
        special_res      = '0;
        special_res.sign = in_Sign_1 ^ in_Sign_2;
        if (in_Exponent_2 == '0) begin
            special_res.dbz = 1'b1;
            special_res.exp = EXP_ALL_ONES;
            special_res.man = (in_Exponent_1 == '0) ? QNAN_MAN : '0;
        end
    end

    assign res_d = (state_q == NORM) ? norm_res : special_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      res_q <= '0;
        else if (res_we) res_q <= res_d;
    end

    assign out_Sign           = res_q.sign;
    assign out_Exponent       = res_q.exp;
    assign out_Mantissa       = res_q.man;
    assign Exponent_Overflow  = res_q.ovf;
    assign Exponent_Underflow = res_q.unf;
    assign Div_By_Zero        = res_q.dbz;

endmodule
